// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states,
// ALU codes, condition codes, datapath mux selects and the ALU decode helper.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] ALUSRCA_REG   = 2'b00;
  localparam logic [1:0] ALUSRCA_PC    = 2'b01;
  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b10;
  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  // Funct[4:1] of a data-processing op; unsupported opcodes fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] op);
    case (op)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_condcheck.sv
// Evaluates an ARM condition field against the {N,Z,C,V} flags.
module condcheck
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v, ge;
  assign {n, z, c, v} = flags;
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = z | ~ge;
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Main instruction FSM, ALU/instruction decoders, NZCV flag register and
// condition-gated architectural write strobes for the multicycle ARM core.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);
  state_t     state, state_next;
  ctrl_t      ctl;
  logic [1:0] flag_w;
  logic [3:0] flags;
  logic       cond_raw, cond_ex, cond_ex_d, pcs;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE:
        case (Op)
          2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.ir_write   = 1'b1;
        ctl.next_pc    = 1'b1;
        ctl.alu_src_a  = ALUSRCA_PC;
        ctl.alu_src_b  = ALUSRCB_FOUR;
        ctl.result_src = RESULT_ALU;
      end
      S_DECODE: begin
        ctl.alu_src_a  = ALUSRCA_PC;
        ctl.alu_src_b  = ALUSRCB_FOUR;
        ctl.result_src = RESULT_ALU;
      end
      S_MEMADR: begin
        ctl.alu_src_a = ALUSRCA_REG;
        ctl.alu_src_b = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctl.adr_src    = 1'b1;
        ctl.result_src = RESULT_ALUOUT;
      end
      S_MEMWB: begin
        ctl.result_src = RESULT_DATA;
        ctl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctl.adr_src    = 1'b1;
        ctl.result_src = RESULT_ALUOUT;
        ctl.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctl.alu_src_a = ALUSRCA_REG;
        ctl.alu_src_b = ALUSRCB_REG;
        ctl.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        ctl.alu_src_a = ALUSRCA_REG;
        ctl.alu_src_b = ALUSRCB_IMM;
        ctl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctl.result_src = RESULT_ALUOUT;
        ctl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = ALUSRCA_REG;
        ctl.alu_src_b  = ALUSRCB_IMM;
        ctl.result_src = RESULT_ALU;
        ctl.branch     = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (ctl.alu_op) begin
      ALUControl = alu_decode(Funct[4:1]);
      flag_w[1]  = Funct[0];
      flag_w[0]  = Funct[0] & (ALUControl == ALU_ADD || ALUControl == ALU_SUB);
    end
  end

  condcheck u_condcheck (.cond(Cond), .flags(flags), .cond_ex(cond_raw));
  assign cond_ex = cond_raw & (Cond != COND_NV);

  // CondExD is loaded every cycle; flags only move in EXECUTE, so the value
  // latched in DECODE holds for the rest of the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_d <= 1'b0;
    end else begin
      cond_ex_d <= cond_ex;
      if (flag_w[1] & cond_ex_d) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex_d) flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs       = ctl.branch | (ctl.reg_w & (Rd == 4'hF));
  assign PCWrite   = ctl.next_pc | (pcs & cond_ex_d);
  assign RegWrite  = ctl.reg_w & cond_ex_d;
  assign MemWrite  = ctl.mem_w & cond_ex_d;
  assign IRWrite   = ctl.ir_write;
  assign AdrSrc    = ctl.adr_src;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;
  assign ResultSrc = ctl.result_src;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == 2'b01, Op == 2'b10};
endmodule
